// File: rtl/gaussian_fir_filter_if.sv
// Sample-path bundle for gaussian_fir_filter: sample in, filtered result and primed status out.
// Pure wiring; the source drives as master, the filter attaches as slave.
interface gaussian_fir_filter_if #(
  parameter int DATA_W = 8
);
  logic              clear;
  logic              mode;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [DATA_W-1:0] filtered_out;
  logic              primed;

  modport master (
    output clear, mode, in_valid, data_in,
    input  out_valid, filtered_out, primed
  );

  modport slave (
    input  clear, mode, in_valid, data_in,
    output out_valid, filtered_out, primed
  );
endinterface

// File: rtl/gaussian_fir_filter.sv
// Streaming TAPS-deep boxcar/binomial FIR, shift-normalised; GAUSS_ROUND_EN selects round-half-up.
// Result one cycle after accept; no back-pressure, one output per accepted sample once primed.
module gaussian_fir_filter #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic            clk,
  input  logic            rst,
  gaussian_fir_filter_if.slave bus
);

  localparam int TAPS      = 1 << LOG2_TAPS;
  localparam int SHIFT_BOX = LOG2_TAPS;
  localparam int SHIFT_BIN = TAPS - 1;
`ifdef GAUSS_ROUND_EN
  localparam int RND_W     = 1;
`else
  localparam int RND_W     = 0;
`endif
  localparam int ACC_W     = DATA_W + SHIFT_BIN + RND_W;
  localparam int CNT_W     = LOG2_TAPS + 1;

  function automatic int binom(input int n, input int k);
    longint c;
    c = 1;
    for (int i = 0; i < k; i++) begin
      c = c * longint'(n - i) / longint'(i + 1);
    end
    return int'(c);
  endfunction

  logic [DATA_W-1:0] win [TAPS];
  logic [CNT_W-1:0]  fill_cnt;
  logic              primed;
  logic              accept;
  logic              pend;
  logic              mode_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] filt_q;
  logic [ACC_W-1:0]  term_bin [TAPS];
  logic [ACC_W-1:0]  acc_box;
  logic [ACC_W-1:0]  acc_bin;
  logic [DATA_W-1:0] result;

  assign accept = bus.in_valid & ~bus.clear;
  assign primed = (fill_cnt == CNT_W'(TAPS));

  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    localparam logic [ACC_W-1:0] COEF = ACC_W'(binom(TAPS - 1, k));
    assign term_bin[k] = COEF * ACC_W'(win[k]);
  end

  always_comb begin
    acc_box = '0;
    acc_bin = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_box = acc_box + ACC_W'(win[k]);
      acc_bin = acc_bin + term_bin[k];
    end
  end

  // Weights sum to 2**SHIFT, so the shifted result always fits DATA_W.
`ifdef GAUSS_ROUND_EN
  localparam logic [ACC_W-1:0] HALF_BOX = ACC_W'(1) << (SHIFT_BOX - 1);
  localparam logic [ACC_W-1:0] HALF_BIN = ACC_W'(1) << (SHIFT_BIN - 1);
  always_comb begin
    result = '0;
    if (mode_q) result = DATA_W'((acc_bin + HALF_BIN) >> SHIFT_BIN);
    else        result = DATA_W'((acc_box + HALF_BOX) >> SHIFT_BOX);
  end
`else
  always_comb begin
    result = '0;
    if (mode_q) result = DATA_W'(acc_bin >> SHIFT_BIN);
    else        result = DATA_W'(acc_box >> SHIFT_BOX);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
      fill_cnt    <= '0;
      pend        <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      filt_q      <= '0;
    end else if (bus.clear) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
      fill_cnt    <= '0;
      pend        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // pend marks a primed accept whose result is published on the following edge
      out_valid_q <= pend;
      if (pend) filt_q <= result;
      pend <= accept & (primed | (fill_cnt == CNT_W'(TAPS - 1)));
      if (accept) begin
        for (int k = 0; k < TAPS - 1; k++) win[k] <= win[k+1];
        win[TAPS-1] <= bus.data_in;
        mode_q      <= bus.mode;
        if (!primed) fill_cnt <= fill_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.filtered_out = filt_q;
  assign bus.primed       = primed;

  a_valid_needs_primed: assert property (
    @(posedge clk) disable iff (rst) out_valid_q |-> primed
  );

endmodule
